lsu_sram_ctrl: RTL and testbench
================================

LSU_SRAM_CTRL -- requirements
Module: lsu_sram_ctrl

Interface
REQ-001 SHALL have: i_clk  in  1  clock; all state changes on posedge.
REQ-002 SHALL have: i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: i_req  in  1  MEM stage holds a load/store this cycle.
REQ-004 SHALL have: i_we  in  1  1=store, 0=load.
REQ-005 SHALL have: i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have: i_addr  in  32  byte address; i_wdata  in  32  store data.
REQ-007 SHALL have: o_stall  out  1  hold pipeline registers.
REQ-008 SHALL have: o_ld_data  out  32  extended load result; o_done  out  1  access-complete pulse.
REQ-009 SHALL have: o_misaligned  out  1  alignment fault; o_bus_err  out  1  SRAM timeout.
REQ-010 SHALL have: o_sram_req  out  1; o_sram_we  out  1; o_sram_addr  out  18  word address (i_addr[19:2]); o_sram_wdata  out  32; o_sram_bmask  out  4.
REQ-011 SHALL have: i_sram_ack  in  1; i_sram_rdata  in  32.

Function
REQ-012 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-013 IDLE with i_req, legal funct3 and aligned address: o_stall=1 combinationally that cycle; latch addr, we, funct3, lane-aligned wdata and bmask; next state ACCESS.
REQ-014 Aligned means: B/BU any; H/HU addr[0]=0; W addr[1:0]=0.
REQ-015 IDLE with i_req and misaligned address: o_misaligned=1 combinationally, o_stall=0, no SRAM request, state stays IDLE.
REQ-016 IDLE with i_req and illegal funct3 (011, 110, 111): no access, no stall, no flag.
REQ-017 ACCESS: o_sram_req=1 with addr/we/wdata/bmask stable from latched values until i_sram_ack; o_stall=1.
REQ-018 ACCESS with i_sram_ack: register extended i_sram_rdata (loads) into o_ld_data; next state DONE.
REQ-019 4-bit wait counter clears on ACCESS entry, increments each ACCESS cycle without ack; at 15 without ack: next state DONE, o_bus_err=1 in DONE, o_ld_data=0.
REQ-020 Ack and timeout in the same cycle: ack wins, o_bus_err=0.
REQ-021 DONE: o_stall=0, o_done=1 for one cycle, o_sram_req=0; i_req in DONE is the same instruction and SHALL be ignored; next state IDLE.
REQ-022 Minimum load/store latency: 3 cycles (IDLE, ACCESS with ack, DONE); stall asserted in IDLE and ACCESS only.
REQ-023 Store lanes: SB replicates wdata[7:0] x4, bmask = 1<<addr[1:0]; SH replicates wdata[15:0] x2, bmask 0011/1100 by addr[1]; SW bmask 1111.
REQ-024 Load extract: byte/half chosen by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-025 o_ld_data holds value until next DONE; stores leave it unchanged.
REQ-026 i_sram_ack outside ACCESS SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, o_ld_data 0, latched addr/data/mask 0; o_sram_req, o_done, o_bus_err deassert at the first clock edge with i_rst_n=0.
REQ-028 Reset mid-ACCESS SHALL abandon the access; no o_done pulse follows.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum, funct3 localparams and TIMEOUT=15.
REQ-030 Load extraction SHALL be sub-module lsu_ld_align (combinational: rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-031 LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> o_sram_addr 0x40, o_done in 3rd cycle, o_ld_data 0xDEADBEEF.
REQ-032 LB addr 0x103, rdata 0x80FF_FF00 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-033 SB addr 0x201, wdata 0x12345678 -> o_sram_wdata 0x78787878, bmask 0010, we=1.
REQ-034 LW addr 0x102 -> o_misaligned=1 that cycle, o_stall=0, o_sram_req never asserted.
REQ-035 No ack for 15 ACCESS cycles -> o_bus_err=1, o_done=1, o_ld_data 0, o_sram_req drops.
REQ-036 Reset asserted 2 cycles into ACCESS -> o_sram_req=0 and state IDLE next edge, no o_done.

Source files
------------

// File: rtl/lsu_sram_ctrl_pkg.sv
// Shared definitions for the load/store unit SRAM controller.
//   lsu_state_e    : controller FSM states
//   F3_*           : load/store width encodings carried on funct3
//   TIMEOUT        : wait-counter value at which a missing ack becomes a bus error
//   SRAM_AW        : SRAM word-address width
//   f3_legal       : funct3 names a supported access width
//   addr_aligned   : byte address is naturally aligned for the access width
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] TIMEOUT = 4'd15;

    localparam int unsigned SRAM_AW = 18;

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = (lo[0] == 1'b0);
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// SRAM-side bus of the LSU controller.
//   o_sram_req   : access request, held until ack
//   o_sram_we    : 1 = write
//   o_sram_addr  : word address
//   o_sram_wdata : lane-replicated write data
//   o_sram_bmask : byte-lane write enables
//   i_sram_ack   : access accepted / read data valid
//   i_sram_rdata : read data
// Modport master is the controller, slave is the SRAM.
interface lsu_sram_ctrl_if;
    import lsu_pkg::*;

    logic               o_sram_req;
    logic               o_sram_we;
    logic [SRAM_AW-1:0] o_sram_addr;
    logic [31:0]        o_sram_wdata;
    logic [3:0]         o_sram_bmask;
    logic               i_sram_ack;
    logic [31:0]        i_sram_rdata;

    modport master (
        output o_sram_req, o_sram_we, o_sram_addr, o_sram_wdata, o_sram_bmask,
        input  i_sram_ack, i_sram_rdata
    );

    modport slave (
        input  o_sram_req, o_sram_we, o_sram_addr, o_sram_wdata, o_sram_bmask,
        output i_sram_ack, i_sram_rdata
    );
endinterface

// File: rtl/lsu_sram_ctrl_ld_align.sv
// Load data alignment and extension (combinational).
//   i_rdata   : raw 32-bit SRAM word
//   i_addr_lo : byte offset within the word
//   i_funct3  : access width / signedness
//   o_data    : selected byte/half, sign- or zero-extended; full word for W
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (i_addr_lo)
            2'd0:    byte_sel = i_rdata[7:0];
            2'd1:    byte_sel = i_rdata[15:8];
            2'd2:    byte_sel = i_rdata[23:16];
            default: byte_sel = i_rdata[31:24];
        endcase

        half_sel = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_data = {24'h000000, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_data = {16'h0000, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// MEM-stage load/store controller driving a single-port SRAM with
// request/ack handshake and a bounded wait.
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_req, i_we          : load/store present this cycle, 1 = store
//   i_funct3             : access width / signedness
//   i_addr, i_wdata      : byte address, store data
//   o_stall              : hold pipeline registers
//   o_ld_data            : extended load result (held until next completion)
//   o_done               : one-cycle completion pulse
//   o_misaligned         : alignment fault (combinational, request cycle)
//   o_bus_err            : SRAM did not ack in time (valid with o_done)
//   sram                 : SRAM bus (master side)
module lsu_sram_ctrl
    import lsu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_stall,
    output logic [31:0]           o_ld_data,
    output logic                  o_done,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    lsu_sram_ctrl_if.master       sram
);

    lsu_state_e  state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bmask_q, bmask_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        bus_err_q, bus_err_d;
    logic        done_q, done_d;
    logic        sram_req_q, sram_req_d;

    logic        req_ok;
    logic        start;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_bmask;
    logic [31:0] ld_ext;

    // Only the SRAM-visible address bits are kept.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:20];

    lsu_ld_align u_ld_align (
        .i_rdata   (sram.i_sram_rdata),
        .i_addr_lo (addr_q[1:0]),
        .i_funct3  (f3_q),
        .o_data    (ld_ext)
    );

    always_comb begin
        case (i_funct3)
            F3_B, F3_BU: begin
                lane_wdata = {4{i_wdata[7:0]}};
                lane_bmask = 4'b0001 << i_addr[1:0];
            end
            F3_H, F3_HU: begin
                lane_wdata = {2{i_wdata[15:0]}};
                lane_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = i_wdata;
                lane_bmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        req_ok     = (state_q == ST_IDLE) && i_req && f3_legal(i_funct3);
        start      = req_ok && addr_aligned(i_funct3, i_addr[1:0]);
        misaligned = req_ok && !addr_aligned(i_funct3, i_addr[1:0]);

        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        f3_d      = f3_q;
        wdata_d   = wdata_q;
        bmask_d   = bmask_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        bus_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCESS;
                    addr_d  = i_addr[19:0];
                    we_d    = i_we;
                    f3_d    = i_funct3;
                    wdata_d = lane_wdata;
                    bmask_d = lane_bmask;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (sram.i_sram_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        ld_data_d = ld_ext;
                    end
                end else if (cnt_q == TIMEOUT - 4'd1) begin
                    // The counter reaches TIMEOUT on this edge: the access has
                    // spent TIMEOUT cycles without an ack. Ack has priority above.
                    state_d   = ST_DONE;
                    cnt_d     = TIMEOUT;
                    bus_err_d = 1'b1;
                    ld_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                // DONE: a held i_req is the instruction just completed.
                state_d = ST_IDLE;
            end
        endcase

        sram_req_d = (state_d == ST_ACCESS);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            bus_err_q  <= 1'b0;
            done_q     <= 1'b0;
            sram_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            bmask_q    <= bmask_d;
            cnt_q      <= cnt_d;
            ld_data_q  <= ld_data_d;
            bus_err_q  <= bus_err_d;
            done_q     <= done_d;
            sram_req_q <= sram_req_d;
        end
    end

    assign o_stall      = start || (state_q == ST_ACCESS);
    assign o_misaligned = misaligned;
    assign o_ld_data    = ld_data_q;
    assign o_done       = done_q;
    assign o_bus_err    = bus_err_q;

    assign sram.o_sram_req   = sram_req_q;
    assign sram.o_sram_we    = we_q;
    assign sram.o_sram_addr  = addr_q[19:2];
    assign sram.o_sram_wdata = wdata_q;
    assign sram.o_sram_bmask = bmask_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Self-checking bench for lsu_sram_ctrl: directed cases followed by random
// transactions, checked against an arithmetic model of the access rules.
module tb_lsu_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        done;
    logic        misaligned;
    logic        bus_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_ld   = '0;

    lsu_sram_ctrl_if sram_bus ();

    lsu_sram_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_we         (we),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_ld_data    (ld_data),
        .o_done       (done),
        .o_misaligned (misaligned),
        .o_bus_err    (bus_err),
        .sram         (sram_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned ref_size(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic ref_legal(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (ref_size(f3))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_bmask(input logic [2:0] f3, input logic [31:0] a);
        case (ref_size(f3))
            1:       return 32'd1 << (a % 4);
            2:       return ((a % 4) == 2) ? 32'hC : 32'h3;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (ref_size(f3))
            1: begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            2: begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // One aligned access. ack_at = ACCESS cycle index (0-based) on which the
    // SRAM acks; any value >= 15 means the SRAM never answers.
    task automatic run_txn(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [31:0] t_rdata,
                           input int unsigned ack_at);
        logic        fin;
        logic        timeout;
        int unsigned acc_cycles;
        req    = 1'b1;
        we     = t_we;
        funct3 = t_f3;
        addr   = t_addr;
        wdata  = t_wdata;
        sram_bus.i_sram_ack = 1'b0;
        #1;
        chk("idle_stall", stall, 1);
        chk("idle_misaligned", misaligned, 0);
        chk("idle_sram_req", sram_bus.o_sram_req, 0);
        @(posedge clk); #1;
        fin = 1'b0;
        acc_cycles = 0;
        for (int unsigned k = 0; k < 15 && !fin; k++) begin
            acc_cycles++;
            chk("acc_sram_req", sram_bus.o_sram_req, 1);
            chk("acc_stall", stall, 1);
            chk("acc_done", done, 0);
            chk("acc_addr", {14'b0, sram_bus.o_sram_addr}, (t_addr >> 2) & 32'h3FFFF);
            chk("acc_we", sram_bus.o_sram_we, t_we);
            chk("acc_wdata", sram_bus.o_sram_wdata, ref_wdata(t_f3, t_wdata));
            chk("acc_bmask", {28'b0, sram_bus.o_sram_bmask}, ref_bmask(t_f3, t_addr));
            // Pipeline inputs wander; the controller must use latched values.
            addr  = $urandom;
            wdata = $urandom;
            sram_bus.i_sram_ack   = (k == ack_at);
            sram_bus.i_sram_rdata = (k == ack_at) ? t_rdata : $urandom;
            @(posedge clk); #1;
            if (k == ack_at || k == 14) fin = 1'b1;
        end
        sram_bus.i_sram_ack = 1'b0;
        timeout = (ack_at >= 15);
        if (timeout) exp_ld = '0;
        else if (!t_we) exp_ld = ref_load(t_f3, t_addr, t_rdata);
        chk("acc_cycles", acc_cycles, timeout ? 15 : ack_at + 1);
        chk("done_pulse", done, 1);
        chk("done_stall", stall, 0);
        chk("done_sram_req", sram_bus.o_sram_req, 0);
        chk("done_bus_err", bus_err, timeout);
        chk("done_ld_data", ld_data, exp_ld);
        @(posedge clk); #1;
        req = 1'b0;
        #1;
        chk("post_done", done, 0);
        chk("post_sram_req", sram_bus.o_sram_req, 0);
        chk("post_bus_err", bus_err, 0);
        chk("post_ld_data", ld_data, exp_ld);
    endtask

    // A request that must be refused in IDLE (misaligned or illegal funct3).
    task automatic run_reject(input logic [2:0] t_f3, input logic [31:0] t_addr,
                              input logic exp_mis);
        req    = 1'b1;
        we     = 1'b0;
        funct3 = t_f3;
        addr   = t_addr;
        #1;
        chk("rej_misaligned", misaligned, exp_mis);
        chk("rej_stall", stall, 0);
        chk("rej_sram_req", sram_bus.o_sram_req, 0);
        @(posedge clk); #1;
        req = 1'b0;
        #1;
        chk("rej_next_sram_req", sram_bus.o_sram_req, 0);
        chk("rej_next_done", done, 0);
        chk("rej_next_ld", ld_data, exp_ld);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  rf3;
        logic [31:0] raddr;
        int unsigned r;
        int unsigned rack;

        rst_n  = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        funct3 = '0;
        addr   = '0;
        wdata  = '0;
        sram_bus.i_sram_ack   = 1'b0;
        sram_bus.i_sram_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sram_req", sram_bus.o_sram_req, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_sram_addr", {14'b0, sram_bus.o_sram_addr}, 0);
        chk("rst_sram_wdata", sram_bus.o_sram_wdata, 0);
        chk("rst_sram_bmask", {28'b0, sram_bus.o_sram_bmask}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray ack in IDLE is ignored
        sram_bus.i_sram_ack = 1'b1;
        @(posedge clk); #1;
        sram_bus.i_sram_ack = 1'b0;
        chk("stray_ack_req", sram_bus.o_sram_req, 0);
        chk("stray_ack_done", done, 0);

        // Directed cases
        run_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_value", ld_data, 32'hDEADBEEF);
        run_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0);
        chk("lb_value", ld_data, 32'hFFFFFF80);
        run_txn(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1);
        chk("lbu_value", ld_data, 32'h00000080);
        run_txn(1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h80FF_FF00, 2);
        chk("lhu_value", ld_data, 32'h000080FF);
        run_txn(1'b1, 3'd0, 32'h0000_0201, 32'h12345678, 32'hFFFF_FFFF, 0);
        chk("sb_keeps_ld", ld_data, 32'h000080FF);
        run_reject(3'd2, 32'h0000_0102, 1'b1);
        run_reject(3'd3, 32'h0000_0100, 1'b0);
        run_reject(3'd6, 32'h0000_0101, 1'b0);
        run_txn(1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 20);
        chk("timeout_ld_zero", ld_data, 0);
        run_txn(1'b0, 3'd1, 32'h0000_0406, 32'h0, 32'h9234_5678, 14);

        // Reset two cycles into ACCESS abandons the access
        req    = 1'b1;
        we     = 1'b0;
        funct3 = 3'd2;
        addr   = 32'h0000_0300;
        @(posedge clk); #1;
        chk("rstacc_req1", sram_bus.o_sram_req, 1);
        @(posedge clk); #1;
        chk("rstacc_req2", sram_bus.o_sram_req, 1);
        rst_n = 1'b0;
        req   = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_req_drop", sram_bus.o_sram_req, 0);
        chk("rstacc_done", done, 0);
        chk("rstacc_stall", stall, 0);
        chk("rstacc_ld", ld_data, 0);
        exp_ld = '0;
        rst_n = 1'b1;
        sram_bus.i_sram_ack = 1'b1;
        @(posedge clk); #1;
        sram_bus.i_sram_ack = 1'b0;
        chk("rstacc_no_done", done, 0);
        chk("rstacc_idle", sram_bus.o_sram_req, 0);

        // Random traffic
        for (int unsigned i = 0; i < 40; i++) begin
            rf3   = f3_tab[$urandom_range(0, 4)];
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0)
                raddr = raddr - (raddr % ref_size(rf3));
            r    = $urandom_range(0, 9);
            rack = (r < 6) ? r : ((r < 8) ? 14 : 20);
            if (ref_legal(rf3) && (raddr % ref_size(rf3)) == 0)
                run_txn(1'($urandom_range(0, 1)), rf3, raddr, $urandom, $urandom, rack);
            else
                run_reject(rf3, raddr, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
